// File: rtl/data_ram_reader_if.sv
// Avalon-MM read master to the data RAM plus the Avalon-ST source that
// carries the fetched words downstream.
interface data_ram_reader_if;
    logic [7:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic        ram_clken;
    logic [31:0] ram_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;

    modport master (
        output ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken,
        input  ram_readdata,
        output out_data, out_valid, out_startofpacket, out_endofpacket,
        input  out_ready
    );

    modport slave (
        input  ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken,
        output ram_readdata,
        input  out_data, out_valid, out_startofpacket, out_endofpacket,
        output out_ready
    );
endinterface

// File: rtl/data_ram_reader.sv
// Streams a block of words out of a 1-cycle-latency data RAM into an
// Avalon-ST source, with a small skid FIFO absorbing downstream back-pressure.
module data_ram_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic [8:0] length,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    data_ram_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    remain_q, remain_d;
    logic          first_q, first_d;
    logic          inflight_q, inflight_d;
    logic          infl_sop_q, infl_sop_d;
    logic          infl_eop_q, infl_eop_d;
    logic          zero_done_q, zero_done_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;

    logic issue, push, pop, complete, out_valid;

    // Reserve a FIFO slot for the word still in the RAM pipeline before issuing.
    assign issue    = (state_q == RUN) && (remain_q != 9'd0) &&
                      ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign push     = inflight_q;
    assign out_valid = (count_q != '0);
    assign pop      = out_valid && bus.out_ready;
    assign complete = (state_q == RUN) && (remain_q == 9'd0) && !inflight_q && (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        first_d     = first_q;
        inflight_d  = 1'b0;
        infl_sop_d  = infl_sop_q;
        infl_eop_d  = infl_eop_q;
        zero_done_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 9'd0) begin
                        state_d  = RUN;
                        addr_d   = base_addr;
                        remain_d = (length > 9'd256) ? 9'd256 : length;
                        first_d  = 1'b1;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d  = IDLE;
                    remain_d = 9'd0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (issue) begin
                        addr_d     = addr_q + 8'd1;
                        remain_d   = remain_q - 9'd1;
                        first_d    = 1'b0;
                        inflight_d = 1'b1;
                        infl_sop_d = first_q;
                        infl_eop_d = (remain_q == 9'd1);
                    end
                    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(push) - CW'(pop);
                    if (complete) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 8'd0;
            remain_q    <= 9'd0;
            first_q     <= 1'b0;
            inflight_q  <= 1'b0;
            infl_sop_q  <= 1'b0;
            infl_eop_q  <= 1'b0;
            zero_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            first_q     <= first_d;
            inflight_q  <= inflight_d;
            infl_sop_q  <= infl_sop_d;
            infl_eop_q  <= infl_eop_d;
            zero_done_q <= zero_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{sop: infl_sop_q, eop: infl_eop_q, data: bus.ram_readdata};
    end

    assign busy = (state_q == RUN) && !complete;
    assign done = zero_done_q || complete;

    assign bus.ram_address       = addr_q;
    assign bus.ram_chipselect    = issue;
    assign bus.ram_write         = 1'b0;
    assign bus.ram_byteenable    = 4'hF;
    assign bus.ram_clken         = 1'b1;
    assign bus.out_valid         = out_valid;
    assign bus.out_data          = out_valid ? head.data : 32'd0;
    assign bus.out_startofpacket = out_valid && head.sop;
    assign bus.out_endofpacket   = out_valid && head.eop;
endmodule
